sdram_pixel_writer: RTL and testbench

- Write-side companion of the SDRAM read-back path: accepts an 8-bit pixel stream from the fractal compute engine and packs 4 pixels per 32-bit word.
- Buffers packed words in an internal word FIFO and drains them to the as4c4m32s controller as fixed-length CMD_WRITE bursts.
- Addresses are linear, wrapping at the frame size.
- Sits in the MEM_CLK domain. The top level arbitrates the single controller port between this block and the display reader via o_Req/i_Grant.

---
 rtl/sdram_pixel_writer.sv | 171 +++++++++++++++++
 tb/tb_sdram_pixel_writer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pixel_writer.sv
// Packs an 8-bit pixel stream into 32-bit words and drains them to the SDRAM controller in CMD_WRITE bursts.
// Optional flush of partial data is built when SDRAM_WRITER_FLUSH_EN is defined.

module sdram_pixel_writer_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
endmodule

module sdram_pixel_writer #(
  parameter int BURST_LENGTH = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_WORDS  = 96000,
  parameter int ADDR_WIDTH   = 22
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      i_Pixel,
  input  logic                            i_Pixel_Valid,
  output logic                            o_Pixel_Ready,
  input  logic                            i_Flush,
  output logic                            o_Req,
  input  logic                            i_Grant,
  output logic [1:0]                      o_Command,
  output logic [ADDR_WIDTH-1:0]           o_Data_Address,
  output logic [31:0]                     o_Data_Write,
  input  logic                            i_Data_Write_Done,
  output logic                            o_Frame_Done,
  output logic [$clog2(FIFO_DEPTH):0]     o_Fifo_Used
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int UW = PW + 1;
  localparam logic [1:0]            CMD_IDLE  = 2'd0;
  localparam logic [1:0]            CMD_WRITE = 2'd1;
  localparam logic [UW-1:0]         BL_U      = UW'(BURST_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST} state_t;

  state_t          state;
  logic [1:0]      byte_idx;
  logic [2:0][7:0] lane_q;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [UW-1:0]   wr_ptr, rd_ptr, used, burst_cnt;
  logic            full, accept, push, pop, pad_push;
  logic [31:0]     push_word, pad_word;

  assign used         = wr_ptr - rd_ptr;
  assign full         = (used == UW'(FIFO_DEPTH));
  assign o_Fifo_Used  = used;
  assign accept       = i_Pixel_Valid && o_Pixel_Ready;
  assign pop          = (state == S_BURST) && i_Data_Write_Done;
  assign o_Data_Write = mem[rd_ptr[PW-1:0]];

  // Byte lanes 0..2 hold the partial word; lane 3 goes straight from i_Pixel into the FIFO.
  for (genvar k = 0; k < 3; k++) begin : g_lane
    sdram_pixel_writer_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .ld   (accept && (byte_idx == 2'(k))),
      .d    (i_Pixel),
      .q    (lane_q[k])
    );
  end

`ifdef SDRAM_WRITER_FLUSH_EN
  logic flush_pend;

  // Lanes at or above byte_idx hold stale bytes from an earlier word; zero them.
  always_comb begin
    pad_word = '0;
    for (int k = 0; k < 3; k++)
      if (2'(k) < byte_idx) pad_word[8*k +: 8] = lane_q[k];
  end

  // A full burst takes priority over padding, so the pad never lands in a full FIFO.
  assign pad_push      = (state == S_IDLE) && flush_pend && (byte_idx != 2'd0) && (used < BL_U);
  assign o_Pixel_Ready = !((byte_idx == 2'd3) && full) && !(flush_pend && (byte_idx != 2'd0));
`else
  logic unused_flush;
  assign unused_flush  = i_Flush;
  assign pad_word      = '0;
  assign pad_push      = 1'b0;
  assign o_Pixel_Ready = !((byte_idx == 2'd3) && full);
`endif

  assign push      = (accept && (byte_idx == 2'd3)) || pad_push;
  assign push_word = pad_push ? pad_word : {i_Pixel, lane_q[2], lane_q[1], lane_q[0]};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      byte_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (pad_push)    byte_idx <= '0;
      else if (accept) byte_idx <= byte_idx + 2'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[PW-1:0]] <= push_word;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= S_IDLE;
      o_Req          <= 1'b0;
      o_Command      <= CMD_IDLE;
      o_Data_Address <= '0;
      o_Frame_Done   <= 1'b0;
      burst_cnt      <= '0;
`ifdef SDRAM_WRITER_FLUSH_EN
      flush_pend     <= 1'b0;
`endif
    end else begin
      o_Frame_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (used >= BL_U) begin
            o_Req     <= 1'b1;
            burst_cnt <= BL_U - 1'b1;
            state     <= S_REQ;
          end
`ifdef SDRAM_WRITER_FLUSH_EN
          else if (flush_pend && (byte_idx == 2'd0)) begin
            flush_pend <= 1'b0;
            if (used != '0) begin
              o_Req     <= 1'b1;
              burst_cnt <= used - 1'b1;
              state     <= S_REQ;
            end
          end
`endif
        end
        S_REQ:
          if (i_Grant) begin
            o_Command <= CMD_WRITE;
            state     <= S_BURST;
          end
        S_BURST:
          // Grant is not re-examined here: once started, the burst runs to completion.
          if (i_Data_Write_Done) begin
            if (o_Data_Address == LAST_ADDR) begin
              o_Data_Address <= '0;
              o_Frame_Done   <= 1'b1;
            end else begin
              o_Data_Address <= o_Data_Address + 1'b1;
            end
            if (burst_cnt == '0) begin
              o_Command <= CMD_IDLE;
              o_Req     <= 1'b0;
              state     <= S_IDLE;
            end else begin
              burst_cnt <= burst_cnt - 1'b1;
            end
          end
        default: state <= S_IDLE;
      endcase
`ifdef SDRAM_WRITER_FLUSH_EN
      if (i_Flush) flush_pend <= 1'b1;
`endif
    end

endmodule

// File: tb/tb_sdram_pixel_writer.sv
// Scoreboard bench for sdram_pixel_writer: a byte/word queue model predicts every written word and address.
`timescale 1ns/1ps
module tb_sdram_pixel_writer;
  localparam int BL    = 8;
  localparam int DEPTH = 16;
  localparam int FW    = 12;
  localparam int AW    = 22;
  localparam int UW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    i_Pixel = '0;
  logic          i_Pixel_Valid = 1'b0;
  logic          o_Pixel_Ready;
  logic          i_Flush = 1'b0;
  logic          o_Req;
  logic          i_Grant = 1'b0;
  logic [1:0]    o_Command;
  logic [AW-1:0] o_Data_Address;
  logic [31:0]   o_Data_Write;
  logic          i_Data_Write_Done = 1'b0;
  logic          o_Frame_Done;
  logic [UW-1:0] o_Fifo_Used;

  sdram_pixel_writer #(
    .BURST_LENGTH(BL), .FIFO_DEPTH(DEPTH), .FRAME_WORDS(FW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_Pixel(i_Pixel), .i_Pixel_Valid(i_Pixel_Valid), .o_Pixel_Ready(o_Pixel_Ready),
    .i_Flush(i_Flush), .o_Req(o_Req), .i_Grant(i_Grant), .o_Command(o_Command),
    .o_Data_Address(o_Data_Address), .o_Data_Write(o_Data_Write),
    .i_Data_Write_Done(i_Data_Write_Done), .o_Frame_Done(o_Frame_Done), .o_Fifo_Used(o_Fifo_Used)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   data;
    logic [AW-1:0] addr;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  part[4];
  int          pcnt = 0, wcnt = 0;
  int          written = 0, fd_count = 0, burst_words = 0;
  int          exp_burst_len = BL;
  int          done_mode = 0, done_pct = 50, gapmax = 0;
  logic        stray = 1'b0;
  logic [31:0] last_data = '0;
  int          errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_word(input logic [31:0] w);
    wr_t e;
    e.data = w;
    e.addr = AW'(wcnt % FW);
    exp_q.push_back(e);
    wcnt++;
  endtask

  task automatic model_accept(input logic [7:0] b);
    part[pcnt] = b;
    pcnt++;
    if (pcnt == 4) begin
      model_word(32'(part[0]) | (32'(part[1]) << 8) | (32'(part[2]) << 16) | (32'(part[3]) << 24));
      pcnt = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pcnt = 0;
    wcnt = 0;
  endtask

  task automatic send_px(input logic [7:0] b);
    int t = 0;
    repeat ($urandom_range(gapmax)) @(negedge clk);
    i_Pixel = b;
    i_Pixel_Valid = 1'b1;
    #1;
    while (!o_Pixel_Ready && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    if (!o_Pixel_Ready) chk("pixel_accept_timeout", 0, 1);
    else model_accept(b);
    @(negedge clk);
    i_Pixel_Valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    #2;
    while (!(exp_q.size() < BL && o_Command == 2'd0 && !o_Req) && t < 3000) begin
      @(negedge clk); #2;
      t++;
    end
    if (t >= 3000) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_empty();
    int t = 0;
    #2;
    while (!(exp_q.size() == 0 && o_Command == 2'd0 && !o_Req) && t < 3000) begin
      @(negedge clk); #2;
      t++;
    end
    if (t >= 3000) chk("empty_timeout", 0, 1);
  endtask

  // Monitor: drives Done, pops the scoreboard on each accepted word, checks burst length and frame pulses.
  initial begin
    logic prev_cmd = 1'b0, fd_exp = 1'b0, alt = 1'b0, d;
    wr_t  e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cmd = 1'b0; fd_exp = 1'b0; burst_words = 0;
        i_Data_Write_Done = 1'b0;
        continue;
      end
      if (o_Frame_Done || fd_exp) chk("frame_done", o_Frame_Done, fd_exp);
      if (o_Frame_Done) fd_count++;
      fd_exp = 1'b0;
      if (prev_cmd && o_Command == 2'd0) begin
        chk("burst_len", burst_words, exp_burst_len);
        burst_words = 0;
      end
      prev_cmd = (o_Command == 2'd1);
      if (o_Command == 2'd1) begin
        alt = ~alt;
        d = (done_mode == 0) ? alt : ($urandom_range(99) < done_pct);
      end else begin
        d = stray;
      end
      i_Data_Write_Done = d;
      if (d && o_Command == 2'd1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got 0x%0h at 0x%0h expected none", o_Data_Write, o_Data_Address);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", o_Data_Write, e.data);
          chk("wr_addr", o_Data_Address, e.addr);
        end
        last_data = o_Data_Write;
        written++;
        burst_words++;
        if (o_Data_Address == AW'(FW - 1)) fd_exp = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    repeat (3) @(negedge clk);
    chk("rst_used", o_Fifo_Used, 0);
    chk("rst_cmd", o_Command, 0);
    chk("rst_addr", o_Data_Address, 0);
    chk("rst_req", o_Req, 0);
    chk("rst_frame_done", o_Frame_Done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-stream discards the partial word and the buffered word.
    for (int i = 0; i < 6; i++) send_px(8'(8'hA0 + i));
    chk("pre_rst_used", o_Fifo_Used, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_used", o_Fifo_Used, 0);
    chk("midrst_cmd", o_Command, 0);
    chk("midrst_addr", o_Data_Address, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single burst, Done every second cycle.
    done_mode = 0;
    i_Grant = 1'b1;
    w0 = written;
    for (int i = 0; i < 32; i++) send_px(8'(i));
    wait_drain();
    chk("burst_words", written - w0, 8);
    chk("burst_used", o_Fifo_Used, 0);
    chk("burst_cmd", o_Command, 0);

    // Backpressure with grant held low.
    i_Grant = 1'b0;
    done_mode = 1; done_pct = 60;
    for (int i = 0; i < 64; i++) send_px(8'(8'h40 + i));
    chk("bp_used_full", o_Fifo_Used, 16);
    for (int i = 64; i < 67; i++) send_px(8'(8'h40 + i));
    i_Pixel = 8'(8'h40 + 67);
    i_Pixel_Valid = 1'b1;
    #1;
    chk("bp_ready_low", o_Pixel_Ready, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("bp_ready_still_low", o_Pixel_Ready, 0);
    i_Grant = 1'b1;
    for (int i = 67; i < 80; i++) send_px(8'(8'h40 + i));
    wait_drain();
    chk("bp_used_left", o_Fifo_Used, exp_q.size());

    // Grant drops after the 3rd Done; the burst must still finish.
    i_Grant = 1'b0;
    done_mode = 0;
    for (int i = 0; i < 32; i++) send_px(8'(8'hC0 + i));
    i_Grant = 1'b1;
    begin
      int t = 0;
      @(negedge clk); #2;
      while (burst_words < 3 && t < 500) begin @(negedge clk); #2; t++; end
      i_Grant = 1'b0;
      if (t >= 500) chk("gd_start_timeout", 0, 1);
      t = 0;
      while (o_Command != 2'd0 && t < 500) begin @(negedge clk); #2; t++; end
      if (t >= 500) chk("gd_end_timeout", 0, 1);
    end
    chk("gd_used", o_Fifo_Used, 4);
    chk("gd_req", o_Req, 0);
    i_Grant = 1'b1;

    // Randomized traffic: random pixels, gaps, grant and Done rate.
    done_mode = 1;
    gapmax = 2;
    for (int i = 0; i < 144; i++) begin
      done_pct = $urandom_range(90, 20);
      i_Grant = ($urandom_range(3) != 0);
      send_px(8'($urandom));
    end
    gapmax = 0;
    i_Grant = 1'b1;
    wait_drain();
    chk("rand_used", o_Fifo_Used, exp_q.size());

    // Stray Done while idle: no pop.
    for (int i = 0; i < 4; i++) send_px(8'(8'h10 + i));
    repeat (3) @(negedge clk);
    w0 = written;
    #2; stray = 1'b1;
    @(negedge clk); #2; stray = 1'b0;
    @(negedge clk); #2;
    chk("stray_used", o_Fifo_Used, 1);
    chk("stray_cmd", o_Command, 0);
    chk("stray_no_write", written - w0, 0);
    for (int i = 0; i < 28; i++) send_px(8'(8'h14 + i));
    wait_drain();
    chk("pre_flush_used", o_Fifo_Used, 0);

    // Flush of a partial stream.
    w0 = written;
    done_mode = 0;
    for (int i = 0; i < 10; i++) send_px(8'(i));
    #2; i_Flush = 1'b1;
    @(negedge clk); #2; i_Flush = 1'b0;
`ifdef SDRAM_WRITER_FLUSH_EN
    exp_burst_len = 3;
    for (int k = pcnt; k < 4; k++) part[k] = 8'h00;
    model_word(32'(part[0]) | (32'(part[1]) << 8) | (32'(part[2]) << 16) | (32'(part[3]) << 24));
    pcnt = 0;
    wait_empty();
    chk("flush_words", written - w0, 3);
    chk("flush_last", last_data, 32'h0000_0908);
    chk("flush_used", o_Fifo_Used, 0);
`else
    repeat (20) @(negedge clk);
    #2;
    chk("noflush_words", written - w0, 0);
    chk("noflush_used", o_Fifo_Used, 2);
`endif

    repeat (4) @(negedge clk);
    chk("frame_done_count", fd_count, written / FW);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
